// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: single-cycle hit path, 32-bit multi-beat line fill on miss,
// optional extra output register stage.
module icache_dm #(
   parameter int unsigned LINE_BITS = 128,
   parameter int unsigned NUM_LINES = 64,
   parameter bit          INC_OREG  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          ifq_pc_in,
   input  logic                 ifq_rd_en,
   input  logic                 ifq_abort,
   input  logic                 inv_all,
   output logic [LINE_BITS-1:0] ifq_dout,
   output logic                 ifq_dout_valid,
   output logic                 ifq_busy,
   output logic                 mem_rd_req,
   output logic [31:0]          mem_addr,
   input  logic                 mem_rd_gnt,
   input  logic                 mem_rd_valid,
   input  logic [31:0]          mem_rd_data
);

   localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
   localparam int unsigned IDX   = $clog2(NUM_LINES);
   localparam int unsigned TAG   = 32 - OFF - IDX;
   localparam int unsigned BEATS = LINE_BITS / 32;
   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam int unsigned LAST  = BEATS - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_RESP
   } state_t;

   state_t               state;
   logic [NUM_LINES-1:0] valid_q;
   logic [LINE_BITS-1:0] data_mem [NUM_LINES];
   logic [TAG-1:0]       tag_mem  [NUM_LINES];

   logic [31-OFF:0]      line_q;
   logic [CNT_W-1:0]     beat_cnt;
   logic [LINE_BITS-1:0] fill_buf;
   logic [LINE_BITS-1:0] fill_line;
   logic                 abort_pend;
   logic                 inv_pend;
   logic [LINE_BITS-1:0] dout_q;
   logic                 dout_valid_q;

   logic [IDX-1:0]       req_idx;
   logic [TAG-1:0]       req_tag;
   logic [IDX-1:0]       fill_idx;
   logic [TAG-1:0]       fill_tag;
   logic                 request;
   logic                 lookup_hit;
   logic                 beat_in;
   logic                 last_beat;
   logic                 unused_pc_bits;

   assign req_idx        = ifq_pc_in[OFF+IDX-1:OFF];
   assign req_tag        = ifq_pc_in[31:OFF+IDX];
   assign fill_idx       = line_q[IDX-1:0];
   assign fill_tag       = line_q[31-OFF:IDX];
   assign request        = ifq_rd_en & ~ifq_abort;
   assign unused_pc_bits = ^ifq_pc_in[OFF-1:0];

   // A same-cycle invalidate must force a miss even if the line is currently resident.
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !inv_all;
   assign beat_in    = (state == S_FILL) && mem_rd_valid;
   assign last_beat  = beat_in && (beat_cnt == CNT_W'(LAST));
   assign ifq_busy   = (state != S_IDLE);

   always_comb begin
      fill_line = fill_buf;
      fill_line[{beat_cnt, 5'b00000} +: 32] = mem_rd_data;
   end

   // Line storage and fill buffer carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (!rst && beat_in) begin
         fill_buf[{beat_cnt, 5'b00000} +: 32] <= mem_rd_data;
      end
      if (!rst && last_beat) begin
         data_mem[fill_idx] <= fill_line;
         tag_mem[fill_idx]  <= fill_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         valid_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         mem_rd_req   <= 1'b0;
         mem_addr     <= '0;
         beat_cnt     <= '0;
         abort_pend   <= 1'b0;
         inv_pend     <= 1'b0;
         line_q       <= '0;
      end else begin
         dout_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (inv_all) begin
                  valid_q <= '0;
               end
               if (request) begin
                  if (lookup_hit) begin
                     dout_q       <= data_mem[req_idx];
                     dout_valid_q <= 1'b1;
                  end else begin
                     line_q     <= ifq_pc_in[31:OFF];
                     mem_addr   <= {ifq_pc_in[31:OFF], {OFF{1'b0}}};
                     mem_rd_req <= 1'b1;
                     state      <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (ifq_abort) begin
                  abort_pend <= 1'b1;
               end
               if (inv_all) begin
                  inv_pend <= 1'b1;
               end
               if (mem_rd_gnt) begin
                  mem_rd_req <= 1'b0;
                  state      <= S_FILL;
               end
            end
            S_FILL: begin
               if (ifq_abort) begin
                  abort_pend <= 1'b1;
               end
               if (inv_all) begin
                  inv_pend <= 1'b1;
               end
               if (mem_rd_valid) begin
                  if (beat_cnt == CNT_W'(LAST)) begin
                     valid_q[fill_idx] <= 1'b1;
                     beat_cnt          <= '0;
                     state             <= S_RESP;
                     // The response is presented while in RESP, so an abort seen on the
                     // final beat still suppresses it.
                     if (!(abort_pend || ifq_abort)) begin
                        dout_q       <= fill_line;
                        dout_valid_q <= 1'b1;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (inv_pend || inv_all) begin
                  valid_q <= '0;
               end
               abort_pend <= 1'b0;
               inv_pend   <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   generate
      if (INC_OREG) begin : g_oreg
         logic [LINE_BITS-1:0] dout_r2;
         logic                 valid_r2;

         always_ff @(posedge clk) begin
            if (rst) begin
               dout_r2  <= '0;
               valid_r2 <= 1'b0;
            end else begin
               dout_r2  <= dout_q;
               valid_r2 <= dout_valid_q;
            end
         end

         assign ifq_dout       = dout_r2;
         assign ifq_dout_valid = valid_r2;
      end else begin : g_no_oreg
         assign ifq_dout       = dout_q;
         assign ifq_dout_valid = dout_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_icache_dm.sv
// Randomised self-checking bench for icache_dm; the reference tracks which line address
// each set holds and reconstructs expected lines from a sparse memory image.
module tb_icache_dm;

   localparam int LB    = 128;
   localparam int NL    = 64;
   localparam int OFFB  = $clog2(LB / 8);
   localparam int IDXB  = $clog2(NL);
   localparam int BEATS = LB / 32;

   logic          clk;
   logic          rst;
   logic [31:0]   ifq_pc_in;
   logic          ifq_rd_en;
   logic          ifq_abort;
   logic          inv_all;
   logic [LB-1:0] ifq_dout;
   logic          ifq_dout_valid;
   logic          ifq_busy;
   logic          mem_rd_req;
   logic [31:0]   mem_addr;
   logic          mem_rd_gnt;
   logic          mem_rd_valid;
   logic [31:0]   mem_rd_data;

   logic [31:0]   b_pc;
   logic          b_rd_en;
   logic          b_abort;
   logic          b_inv;
   logic [255:0]  b_dout;
   logic          b_dout_valid;
   logic          b_busy;
   logic          b_req;
   logic [31:0]   b_addr;
   logic          b_gnt;
   logic          b_beat;
   logic [31:0]   b_data;

   int            checkCount;
   int            errorCount;
   logic [31:0]   memImg [logic [31:0]];
   logic [31:0]   owner [NL];
   bit            ownerValid [NL];
   logic [255:0]  lastDout;

   icache_dm #(.LINE_BITS(LB), .NUM_LINES(NL), .INC_OREG(1'b0)) dut (
      .clk(clk), .rst(rst), .ifq_pc_in(ifq_pc_in), .ifq_rd_en(ifq_rd_en),
      .ifq_abort(ifq_abort), .inv_all(inv_all), .ifq_dout(ifq_dout),
      .ifq_dout_valid(ifq_dout_valid), .ifq_busy(ifq_busy), .mem_rd_req(mem_rd_req),
      .mem_addr(mem_addr), .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid),
      .mem_rd_data(mem_rd_data)
   );

   icache_dm #(.LINE_BITS(256), .NUM_LINES(16), .INC_OREG(1'b1)) dut2 (
      .clk(clk), .rst(rst), .ifq_pc_in(b_pc), .ifq_rd_en(b_rd_en),
      .ifq_abort(b_abort), .inv_all(b_inv), .ifq_dout(b_dout),
      .ifq_dout_valid(b_dout_valid), .ifq_busy(b_busy), .mem_rd_req(b_req),
      .mem_addr(b_addr), .mem_rd_gnt(b_gnt), .mem_rd_valid(b_beat),
      .mem_rd_data(b_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (!memImg.exists(a)) memImg[a] = $urandom;
      return memImg[a];
   endfunction

   function automatic logic [31:0] lineOf(input logic [31:0] pc);
      return pc & ~32'(LB / 8 - 1);
   endfunction

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> OFFB) & 32'(NL - 1));
   endfunction

   function automatic logic [255:0] lineData(input logic [31:0] la);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < BEATS; k++) r[32*k +: 32] = memWord(la + 32'(4 * k));
      return r;
   endfunction

   function automatic bit modelHit(input logic [31:0] pc);
      return ownerValid[idxOf(pc)] && (owner[idxOf(pc)] == lineOf(pc));
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < NL; i++) ownerValid[i] = 1'b0;
   endfunction

   // One fetch request with optional abort/invalidate, acting as the memory on a miss.
   task automatic applyStimulus(input logic [31:0] pc, input bit abortFill, input bit invFill,
                                input bit invSame, input bit abortSame);
      logic [31:0]  la;
      logic [255:0] expLine;
      bit           expHit;
      la = lineOf(pc);
      if (invSame) clearModel();
      expHit  = modelHit(pc);
      expLine = lineData(la);
      @(negedge clk);
      ifq_pc_in = pc; ifq_rd_en = 1'b1; inv_all = invSame; ifq_abort = abortSame;
      @(negedge clk);
      ifq_rd_en = 1'b0; inv_all = 1'b0; ifq_abort = 1'b0;
      if (abortSame) begin
         checkOutput("abort_same_valid", 256'(ifq_dout_valid), 256'(0));
         checkOutput("abort_same_req", 256'(mem_rd_req), 256'(0));
         checkOutput("abort_same_busy", 256'(ifq_busy), 256'(0));
      end else if (expHit) begin
         checkOutput("hit_valid", 256'(ifq_dout_valid), 256'(1));
         checkOutput("hit_data", 256'(ifq_dout), expLine);
         checkOutput("hit_no_req", 256'(mem_rd_req), 256'(0));
         checkOutput("hit_busy", 256'(ifq_busy), 256'(0));
         lastDout = expLine;
      end else begin
         checkOutput("miss_req", 256'(mem_rd_req), 256'(1));
         checkOutput("miss_addr", 256'(mem_addr), 256'(la));
         checkOutput("miss_busy", 256'(ifq_busy), 256'(1));
         checkOutput("miss_no_valid", 256'(ifq_dout_valid), 256'(0));
         repeat ($urandom_range(0, 2)) begin
            mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
            @(negedge clk);
            mem_rd_valid = 1'b0;
            checkOutput("req_hold", 256'(mem_rd_req), 256'(1));
         end
         mem_rd_gnt = 1'b1;
         @(negedge clk);
         mem_rd_gnt = 1'b0;
         checkOutput("req_drop", 256'(mem_rd_req), 256'(0));
         for (int k = 0; k < BEATS; k++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            mem_rd_valid = 1'b1; mem_rd_data = memWord(la + 32'(4 * k));
            ifq_abort = abortFill && (k == 1);
            inv_all   = invFill && (k == 0);
            @(negedge clk);
            mem_rd_valid = 1'b0; ifq_abort = 1'b0; inv_all = 1'b0;
            if (k < BEATS - 1) checkOutput("fill_no_valid", 256'(ifq_dout_valid), 256'(0));
         end
         checkOutput("resp_busy", 256'(ifq_busy), 256'(1));
         checkOutput("resp_valid", 256'(ifq_dout_valid), 256'(!abortFill));
         if (!abortFill) begin
            checkOutput("resp_data", 256'(ifq_dout), expLine);
            lastDout = expLine;
         end
         owner[idxOf(pc)] = la; ownerValid[idxOf(pc)] = 1'b1;
         if (invFill) clearModel();
         @(negedge clk);
         checkOutput("post_resp_busy", 256'(ifq_busy), 256'(0));
      end
      @(negedge clk);
      checkOutput("idle_no_valid", 256'(ifq_dout_valid), 256'(0));
      checkOutput("dout_hold", 256'(ifq_dout), lastDout);
   endtask

   task automatic backToBack(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
      logic [31:0] pcs [3];
      pcs[0] = p0; pcs[1] = p1; pcs[2] = p2;
      @(negedge clk);
      ifq_pc_in = pcs[0]; ifq_rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i < 2) ifq_pc_in = pcs[i+1];
         else ifq_rd_en = 1'b0;
         checkOutput("b2b_valid", 256'(ifq_dout_valid), 256'(modelHit(pcs[i])));
         checkOutput("b2b_data", 256'(ifq_dout), lineData(lineOf(pcs[i])));
         lastDout = lineData(lineOf(pcs[i]));
      end
      @(negedge clk);
   endtask

   task automatic invIdle();
      @(negedge clk);
      inv_all = 1'b1;
      @(negedge clk);
      inv_all = 1'b0;
      clearModel();
   endtask

   initial begin
      logic [31:0]  pc;
      logic [255:0] exp2;
      int           r;
      checkCount = 0; errorCount = 0; lastDout = '0;
      clearModel();
      rst = 1'b1; ifq_pc_in = '0; ifq_rd_en = 1'b0; ifq_abort = 1'b0; inv_all = 1'b0;
      mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
      b_pc = '0; b_rd_en = 1'b0; b_abort = 1'b0; b_inv = 1'b0;
      b_gnt = 1'b0; b_beat = 1'b0; b_data = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 256'(ifq_busy), 256'(0));
      checkOutput("rst_valid", 256'(ifq_dout_valid), 256'(0));
      checkOutput("rst_dout", 256'(ifq_dout), 256'(0));
      checkOutput("rst_req", 256'(mem_rd_req), 256'(0));
      checkOutput("rst_addr", 256'(mem_addr), 256'(0));
      rst = 1'b0;

      memImg[32'h40] = 32'h11; memImg[32'h44] = 32'h22;
      memImg[32'h48] = 32'h33; memImg[32'h4C] = 32'h44;
      applyStimulus(32'h40, 0, 0, 0, 0);
      checkOutput("cold_line", 256'(ifq_dout), 256'(128'h00000044_00000033_00000022_00000011));
      applyStimulus(32'h48, 0, 0, 0, 0);
      backToBack(32'h40, 32'h44, 32'h48);
      applyStimulus(32'h440, 0, 0, 0, 0);
      applyStimulus(32'h40, 0, 0, 0, 0);
      applyStimulus(32'h80, 1, 0, 0, 0);
      applyStimulus(32'h80, 0, 0, 0, 0);
      applyStimulus(32'hC0, 0, 0, 0, 1);
      applyStimulus(32'h40, 0, 0, 0, 0);
      invIdle();
      applyStimulus(32'h40, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 1, 0, 0);
      applyStimulus(32'h100, 0, 0, 0, 0);
      applyStimulus(32'h100, 0, 0, 1, 0);

      // Reset in the middle of a fill, then stray beats that must be ignored.
      @(negedge clk);
      ifq_pc_in = 32'h200; ifq_rd_en = 1'b1;
      @(negedge clk);
      ifq_rd_en = 1'b0;
      checkOutput("rstfill_req", 256'(mem_rd_req), 256'(!modelHit(32'h200)));
      mem_rd_gnt = 1'b1;
      @(negedge clk);
      mem_rd_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_rd_valid = 1'b1; mem_rd_data = 32'h5A5A_0000 + 32'(k);
         @(negedge clk);
      end
      mem_rd_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clearModel(); lastDout = '0;
      checkOutput("rstfill_busy", 256'(ifq_busy), 256'(0));
      checkOutput("rstfill_req0", 256'(mem_rd_req), 256'(0));
      checkOutput("rstfill_dout", 256'(ifq_dout), 256'(0));
      for (int k = 0; k < 2; k++) begin
         mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0_0000 + 32'(k);
         @(negedge clk);
         checkOutput("late_beat_busy", 256'(ifq_busy), 256'(0));
         checkOutput("late_beat_valid", 256'(ifq_dout_valid), 256'(0));
      end
      mem_rd_valid = 1'b0;
      applyStimulus(32'h40, 0, 0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         pc = (32'($urandom_range(0, 3)) << (OFFB + IDXB)) | (32'($urandom_range(0, 7)) << OFFB)
              | (32'($urandom_range(0, 15)) & 32'hC);
         r = $urandom_range(0, 19);
         if (r == 5) invIdle();
         applyStimulus(pc, (r == 0) || (r == 1), r == 2, r == 3, r == 4);
      end

      // Wide line, shallow cache, extra output register.
      for (int k = 0; k < 8; k++) exp2[32*k +: 32] = 32'hA0 + 32'(k);
      @(negedge clk);
      b_pc = 32'h40; b_rd_en = 1'b1;
      @(negedge clk);
      b_rd_en = 1'b0;
      checkOutput("w_miss_req", 256'(b_req), 256'(1));
      checkOutput("w_miss_addr", 256'(b_addr), 256'(32'h40));
      b_gnt = 1'b1;
      @(negedge clk);
      b_gnt = 1'b0;
      for (int k = 0; k < 8; k++) begin
         b_beat = 1'b1; b_data = 32'hA0 + 32'(k);
         @(negedge clk);
         b_beat = 1'b0;
         if (k < 7) checkOutput("w_fill_busy", 256'(b_busy), 256'(1));
      end
      checkOutput("w_resp_busy", 256'(b_busy), 256'(1));
      checkOutput("w_resp_delay", 256'(b_dout_valid), 256'(0));
      @(negedge clk);
      checkOutput("w_resp_valid", 256'(b_dout_valid), 256'(1));
      checkOutput("w_resp_data", b_dout, exp2);
      checkOutput("w_idle_busy", 256'(b_busy), 256'(0));
      @(negedge clk);
      b_pc = 32'h58; b_rd_en = 1'b1;
      @(negedge clk);
      b_rd_en = 1'b0;
      checkOutput("w_hit_lat1", 256'(b_dout_valid), 256'(0));
      checkOutput("w_hit_no_req", 256'(b_req), 256'(0));
      @(negedge clk);
      checkOutput("w_hit_valid", 256'(b_dout_valid), 256'(1));
      checkOutput("w_hit_data", b_dout, exp2);
      @(negedge clk);
      checkOutput("w_hit_pulse", 256'(b_dout_valid), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
